// File: rtl/dht_sched_pkg.sv
// Shared types for the DHT11 read scheduler: FSM state encoding and
// transaction source encodings reported on last_src.
package dht_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        WAIT    = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic SRC_AUTO = 1'b0;
    localparam logic SRC_CMD  = 1'b1;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider producing a one-cycle pulse every CLK_HZ/1000 cycles.
module ms_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/dht_read_scheduler.sv
// Merges auto/command read requests into spaced dht11 start pulses with timeout.
// Define DHT_SCHED_RETRY_EN to build the retry path and HOLDOFF state.
module dht_read_scheduler
    import dht_sched_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int PERIOD_MS  = 5000,
    parameter int MIN_GAP_MS = 2000,
    parameter int TIMEOUT_MS = 50,
    parameter int MAX_RETRY  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       auto_en,
    input  logic       cmd_req,
    input  logic       sensor_valid,
    output logic       sensor_start,
    output logic       busy,
    output logic       read_done,
    output logic       err,
    output logic       last_src,
    output logic [1:0] retry_cnt,
    output logic [1:0] dbg_state
);

    localparam int PW = $clog2(PERIOD_MS + 1);
    localparam int GW = $clog2(MIN_GAP_MS + 1);
    localparam int TW = $clog2(TIMEOUT_MS + 1);

    state_t        state;
    state_t        state_next;
    logic          ms_tick;
    logic [PW-1:0] period_cnt;
    logic [GW-1:0] gap_cnt;
    logic          gap_skip;
    logic [TW-1:0] tmo_cnt;
    logic          pend_auto;
    logic          pend_cmd;
    logic          period_wrap;
    logic          req_auto;
    logic          req_cmd;
    logic          gap_full;
    logic          tmo_hit;
    logic          launch;
    logic          done_set;
    logic          err_set;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (ms_tick)
    );

    // Requests arriving this cycle are honoured immediately so an idle, rested
    // sensor sees its start pulse one cycle after the request.
    assign period_wrap = auto_en && ms_tick && (period_cnt == PW'(PERIOD_MS - 1));
    assign req_auto    = pend_auto || period_wrap;
    assign req_cmd     = pend_cmd || cmd_req;
    assign gap_full    = (gap_cnt == GW'(MIN_GAP_MS));
    assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT_MS));
    assign dbg_state   = state;

`ifdef DHT_SCHED_RETRY_EN
    logic       retry_inc;
    logic [1:0] retry_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry_q <= 2'd0;
        end else if (launch) begin
            retry_q <= 2'd0;
        end else if (retry_inc) begin
            retry_q <= retry_q + 2'd1;
        end
    end

    assign retry_cnt = retry_q;
`else
    // No retry path: the count is a constant zero whatever MAX_RETRY says.
    assign retry_cnt = 2'(0 * MAX_RETRY);
`endif

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
`ifdef DHT_SCHED_RETRY_EN
        retry_inc  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if ((req_cmd || req_auto) && gap_full) begin
                    launch     = 1'b1;
                    state_next = FIRE;
                end
            end
            FIRE: state_next = WAIT;
            WAIT: begin
                if (sensor_valid) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end else if (tmo_hit) begin
`ifdef DHT_SCHED_RETRY_EN
                    if (retry_q < 2'(MAX_RETRY)) begin
                        retry_inc  = 1'b1;
                        state_next = HOLDOFF;
                    end else begin
                        err_set    = 1'b1;
                        state_next = IDLE;
                    end
`else
                    err_set    = 1'b1;
                    state_next = IDLE;
`endif
                end
            end
`ifdef DHT_SCHED_RETRY_EN
            HOLDOFF: begin
                if (gap_full) state_next = FIRE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            period_cnt   <= '0;
            pend_auto    <= 1'b0;
            pend_cmd     <= 1'b0;
            gap_cnt      <= '0;
            gap_skip     <= 1'b0;
            tmo_cnt      <= '0;
            sensor_start <= 1'b0;
            busy         <= 1'b0;
            read_done    <= 1'b0;
            err          <= 1'b0;
            last_src     <= SRC_AUTO;
        end else begin
            state <= state_next;

            if (!auto_en || period_wrap) begin
                period_cnt <= '0;
            end else if (ms_tick) begin
                period_cnt <= period_cnt + PW'(1);
            end

            if (launch) pend_auto <= 1'b0;
            else if (period_wrap) pend_auto <= 1'b1;
            if (launch) pend_cmd <= 1'b0;
            else if (cmd_req) pend_cmd <= 1'b1;

            // The first tick after a start is a partial ms and is not counted,
            // so consecutive starts are never closer than MIN_GAP_MS.
            if (state == FIRE) begin
                gap_cnt  <= '0;
                gap_skip <= 1'b1;
            end else if (ms_tick) begin
                if (gap_skip) gap_skip <= 1'b0;
                else if (!gap_full) gap_cnt <= gap_cnt + GW'(1);
            end

            if (state == FIRE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT && ms_tick && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            sensor_start <= (state_next == FIRE);
            busy         <= (state_next != IDLE);
            read_done    <= done_set;
            if (done_set) err <= 1'b0;
            else if (err_set) err <= 1'b1;
            if (launch) last_src <= req_cmd ? SRC_CMD : SRC_AUTO;
        end
    end

endmodule
